// File: rtl/secded_pkg.sv
// Purpose: shared constants, state encoding and codeword bit map for the SECDED data memory.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Codeword layout: bit j (0..37) holds Hamming position j+1. Check bits sit at the
// power-of-two positions (bits 0,1,3,7,15,31), data fills the rest in ascending
// order, and bit 38 is even parity over bits 0..37.
package secded_pkg;

    localparam int CW_W    = 39;
    localparam int DATA_W  = 32;
    localparam int CHK_W   = 6;
    localparam int PAR_BIT = 38;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD    = 2'd1,
        SCRUB = 2'd2
    } state_t;

    // Codeword bit index holding data bit i.
    localparam logic [5:0] DATA_POS [DATA_W] = '{
        6'd2,  6'd4,  6'd5,  6'd6,  6'd8,  6'd9,  6'd10, 6'd11,
        6'd12, 6'd13, 6'd14, 6'd16, 6'd17, 6'd18, 6'd19, 6'd20,
        6'd21, 6'd22, 6'd23, 6'd24, 6'd25, 6'd26, 6'd27, 6'd28,
        6'd29, 6'd30, 6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37
    };

    // Codeword bit index holding check bit k (Hamming position 2^k).
    localparam logic [5:0] CHK_POS [CHK_W] = '{
        6'd0, 6'd1, 6'd3, 6'd7, 6'd15, 6'd31
    };

endpackage

// File: rtl/hamming_secded_32.sv
// Purpose: (39,32) Hamming SECDED encoder and decoder, independent datapaths.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no handshake.
//
// Ports: enc_data_i -> enc_cw_o (encode);
//        dec_cw_i -> dec_data_o (single-bit corrected), dec_syn_o, dec_single_o, dec_double_o.
module hamming_secded_32
    import secded_pkg::*;
(
    input  logic [DATA_W-1:0] enc_data_i,
    output logic [CW_W-1:0]   enc_cw_o,
    input  logic [CW_W-1:0]   dec_cw_i,
    output logic [DATA_W-1:0] dec_data_o,
    output logic [CHK_W-1:0]  dec_syn_o,
    output logic              dec_single_o,
    output logic              dec_double_o
);

    logic [CW_W-1:0]  enc_base;
    logic [CHK_W-1:0] enc_chk;
    logic             par_mis;

    // Check bits are computed from a data-only image so a check position never
    // folds its own (partially built) value into its parity.
    always_comb begin
        enc_base = '0;
        for (int i = 0; i < DATA_W; i++) begin
            enc_base[DATA_POS[i]] = enc_data_i[i];
        end
        enc_chk = '0;
        for (int k = 0; k < CHK_W; k++) begin
            for (int j = 0; j < PAR_BIT; j++) begin
                if (((j + 1) & (1 << k)) != 0) begin
                    enc_chk[k] = enc_chk[k] ^ enc_base[j];
                end
            end
        end
        enc_cw_o = enc_base;
        for (int k = 0; k < CHK_W; k++) begin
            enc_cw_o[CHK_POS[k]] = enc_chk[k];
        end
        enc_cw_o[PAR_BIT] = ^enc_cw_o[PAR_BIT-1:0];
    end

    // Syndrome equals the Hamming position (1-based) of a single flipped bit.
    // A syndrome of 0 with parity mismatch means only the overall parity bit flipped,
    // and a syndrome beyond the last data position flips nothing.
    always_comb begin
        dec_syn_o = '0;
        for (int k = 0; k < CHK_W; k++) begin
            for (int j = 0; j < PAR_BIT; j++) begin
                if (((j + 1) & (1 << k)) != 0) begin
                    dec_syn_o[k] = dec_syn_o[k] ^ dec_cw_i[j];
                end
            end
        end
        par_mis      = ^dec_cw_i;
        dec_single_o = par_mis;
        dec_double_o = !par_mis && (dec_syn_o != '0);
        dec_data_o   = '0;
        for (int i = 0; i < DATA_W; i++) begin
            dec_data_o[i] = dec_cw_i[DATA_POS[i]]
                          ^ (par_mis && (dec_syn_o == DATA_POS[i] + 6'd1));
        end
    end

endmodule

// File: rtl/secded_dmem_ctrl.sv
// Purpose: memory-stage data memory storing SECDED codewords, with read correction, scrub and error counters.
// Latency: stores complete in 1 cycle; loads return rd_valid 2 cycles after acceptance (+1 stall cycle for scrub).
// Backpressure: stall_mem is high whenever not IDLE; requests are ignored then and must be held upstream.
//
// Ports: MemWriteM/MemReadM/ALUResultM/WriteDataM pipeline request; inj_en/inj_bit fault injection;
//        ReadDataM/rd_valid/s_err/d_err load result pulses; stall_mem; s_err_cnt/d_err_cnt saturating counters.
module secded_dmem_ctrl
    import secded_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemWriteM,
    input  logic              MemReadM,
    input  logic [31:0]       ALUResultM,
    input  logic [31:0]       WriteDataM,
    input  logic              inj_en,
    input  logic [5:0]        inj_bit,
    output logic [31:0]       ReadDataM,
    output logic              rd_valid,
    output logic              s_err,
    output logic              d_err,
    output logic              stall_mem,
    output logic [CNT_W-1:0]  s_err_cnt,
    output logic [CNT_W-1:0]  d_err_cnt
);

    localparam int IDX_W = $clog2(DEPTH);

    state_t              state_q, state_d;
    logic [CW_W-1:0]     mem_q [DEPTH];
    logic [CW_W-1:0]     cw_q;
    logic [IDX_W-1:0]    idx_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                rd_valid_q, s_err_q, d_err_q;
    logic [CNT_W-1:0]    s_cnt_q, d_cnt_q;

    logic [IDX_W-1:0]    idx;
    logic [DATA_W-1:0]   enc_data;
    logic [CW_W-1:0]     enc_cw;
    logic [DATA_W-1:0]   dec_data;
    logic [CHK_W-1:0]    dec_syn;
    logic                dec_single, dec_double;
    logic                unused_sigs;

    // Word index; byte offset and high address bits are dropped so addresses alias modulo DEPTH.
    assign idx         = ALUResultM[IDX_W+1:2];
    assign unused_sigs = ^{ALUResultM[31:IDX_W+2], ALUResultM[1:0], dec_syn};

    // One encoder serves both stores (IDLE) and scrub write-back (SCRUB). In SCRUB the
    // corrected word is already sitting in the load data register.
    assign enc_data = (state_q == SCRUB) ? rdata_q : WriteDataM;

    hamming_secded_32 u_ecc (
        .enc_data_i   (enc_data),
        .enc_cw_o     (enc_cw),
        .dec_cw_i     (cw_q),
        .dec_data_o   (dec_data),
        .dec_syn_o    (dec_syn),
        .dec_single_o (dec_single),
        .dec_double_o (dec_double)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!MemWriteM && MemReadM) state_d = RD;
            RD:      state_d = dec_single ? SCRUB : IDLE;
            SCRUB:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cw_q       <= '0;
            idx_q      <= '0;
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
            s_err_q    <= 1'b0;
            d_err_q    <= 1'b0;
            s_cnt_q    <= '0;
            d_cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            rd_valid_q <= 1'b0;
            s_err_q    <= 1'b0;
            d_err_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (MemWriteM) begin
                        mem_q[idx] <= enc_cw;
                    end else if (MemReadM) begin
                        cw_q  <= mem_q[idx];
                        idx_q <= idx;
                    end else if (inj_en && (inj_bit <= 6'(PAR_BIT))) begin
                        mem_q[idx] <= mem_q[idx] ^ (CW_W'(1) << inj_bit);
                    end
                end
                RD: begin
                    rdata_q    <= dec_data;
                    rd_valid_q <= 1'b1;
                    s_err_q    <= dec_single;
                    d_err_q    <= dec_double;
                    if (dec_single && (s_cnt_q != '1)) s_cnt_q <= s_cnt_q + 1'b1;
                    if (dec_double && (d_cnt_q != '1)) d_cnt_q <= d_cnt_q + 1'b1;
                end
                SCRUB: begin
                    mem_q[idx_q] <= enc_cw;
                end
                default: ;
            endcase
        end
    end

    assign ReadDataM = rdata_q;
    assign rd_valid  = rd_valid_q;
    assign s_err     = s_err_q;
    assign d_err     = d_err_q;
    assign stall_mem = (state_q != IDLE);
    assign s_err_cnt = s_cnt_q;
    assign d_err_cnt = d_cnt_q;

endmodule

// File: tb/tb_secded_dmem_ctrl.sv
module tb_secded_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        MemWriteM = 1'b0, MemReadM = 1'b0, inj_en = 1'b0;
    logic [31:0] ALUResultM = '0, WriteDataM = '0;
    logic [5:0]  inj_bit = '0;
    logic [31:0] ReadDataM;
    logic        rd_valid, s_err, d_err, stall_mem;
    logic [7:0]  s_err_cnt, d_err_cnt;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] rd;
    logic        rs, rde;
    int          st, vc, vp;

    secded_dmem_ctrl #(.DEPTH(64), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .MemWriteM(MemWriteM), .MemReadM(MemReadM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .inj_en(inj_en), .inj_bit(inj_bit),
        .ReadDataM(ReadDataM), .rd_valid(rd_valid), .s_err(s_err), .d_err(d_err),
        .stall_mem(stall_mem), .s_err_cnt(s_err_cnt), .d_err_cnt(d_err_cnt)
    );

    always #5 clk = ~clk;

    // All drive tasks start and end on a falling edge.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        ALUResultM = a; WriteDataM = d; MemWriteM = 1'b1;
        @(posedge clk); @(negedge clk);
        MemWriteM = 1'b0;
    endtask

    task automatic do_inject(input logic [31:0] a, input logic [5:0] b);
        ALUResultM = a; inj_bit = b; inj_en = 1'b1;
        @(posedge clk); @(negedge clk);
        inj_en = 1'b0;
    endtask

    // Issues a load and observes a bounded window: stall cycles, rd_valid pulses,
    // the position of the first pulse (expected 1 = second cycle after acceptance).
    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic s,
                           output logic de, output int stalls, output int vcnt, output int vpos);
        ALUResultM = a; MemReadM = 1'b1;
        @(posedge clk); @(negedge clk);
        MemReadM = 1'b0;
        d = '0; s = 1'b0; de = 1'b0; stalls = 0; vcnt = 0; vpos = -1;
        for (int i = 0; i < 5; i++) begin
            if (stall_mem) stalls++;
            if (rd_valid) begin
                vcnt++;
                if (vpos < 0) begin
                    vpos = i; d = ReadDataM; s = s_err; de = d_err;
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++; if (ReadDataM !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", ReadDataM); end
        n_cmp++; if ({rd_valid, s_err, d_err, stall_mem} !== 4'b0) begin n_err++; $display("FAIL reset_flags: got %b want 0000", {rd_valid, s_err, d_err, stall_mem}); end
        n_cmp++; if ({s_err_cnt, d_err_cnt} !== 16'h0) begin n_err++; $display("FAIL reset_cnt: got %h want 0000", {s_err_cnt, d_err_cnt}); end
        rst = 1'b1;
        @(negedge clk);
        do_read(32'h10, rd, rs, rde, st, vc, vp);
        n_cmp++; if ({rd, rs, rde} !== {32'h0, 2'b00}) begin n_err++; $display("FAIL reset_array: got %h s=%b d=%b want 0 no error", rd, rs, rde); end
    endtask

    task automatic test_clean();
        do_write(32'h4, 32'h12);
        n_cmp++; if ({stall_mem, rd_valid} !== 2'b00) begin n_err++; $display("FAIL write_nostall: got %b want 00", {stall_mem, rd_valid}); end
        do_read(32'h4, rd, rs, rde, st, vc, vp);
        n_cmp++; if (rd !== 32'h12) begin n_err++; $display("FAIL clean_data: got %h want 00000012", rd); end
        n_cmp++; if ({rs, rde} !== 2'b00) begin n_err++; $display("FAIL clean_flags: got %b want 00", {rs, rde}); end
        n_cmp++; if (st !== 1) begin n_err++; $display("FAIL clean_stall: got %0d want 1", st); end
        n_cmp++; if (vc !== 1 || vp !== 1) begin n_err++; $display("FAIL clean_latency: got pulses=%0d pos=%0d want 1/1", vc, vp); end
    endtask

    task automatic test_single();
        do_inject(32'h4, 6'd10);
        do_read(32'h4, rd, rs, rde, st, vc, vp);
        n_cmp++; if (rd !== 32'h12) begin n_err++; $display("FAIL single_data: got %h want 00000012", rd); end
        n_cmp++; if ({rs, rde} !== 2'b10) begin n_err++; $display("FAIL single_flags: got %b want 10", {rs, rde}); end
        n_cmp++; if (st !== 2) begin n_err++; $display("FAIL single_stall: got %0d want 2", st); end
        n_cmp++; if (s_err_cnt !== 8'd1) begin n_err++; $display("FAIL single_cnt: got %0d want 1", s_err_cnt); end
        do_read(32'h4, rd, rs, rde, st, vc, vp);
        n_cmp++; if ({rd, rs, rde, st} !== {32'h12, 2'b00, 32'd1}) begin n_err++; $display("FAIL single_scrubbed: got %h s=%b d=%b stall=%0d want 12/0/0/1", rd, rs, rde, st); end
    endtask

    task automatic test_double();
        do_inject(32'h4, 6'd3);
        do_inject(32'h4, 6'd20);
        do_read(32'h4, rd, rs, rde, st, vc, vp);
        n_cmp++; if ({rs, rde} !== 2'b01) begin n_err++; $display("FAIL double_flags: got %b want 01", {rs, rde}); end
        n_cmp++; if (rd !== 32'h8012) begin n_err++; $display("FAIL double_raw: got %h want 00008012", rd); end
        n_cmp++; if (st !== 1) begin n_err++; $display("FAIL double_stall: got %0d want 1", st); end
        n_cmp++; if (d_err_cnt !== 8'd1) begin n_err++; $display("FAIL double_cnt1: got %0d want 1", d_err_cnt); end
        do_read(32'h4, rd, rs, rde, st, vc, vp);
        n_cmp++; if (rde !== 1'b1) begin n_err++; $display("FAIL double_again: got %b want 1", rde); end
        n_cmp++; if ({d_err_cnt, s_err_cnt} !== {8'd2, 8'd1}) begin n_err++; $display("FAIL double_cnt2: got d=%0d s=%0d want 2/1", d_err_cnt, s_err_cnt); end
    endtask

    task automatic test_parity();
        do_write(32'h4, 32'h12);
        do_inject(32'h4, 6'd38);
        do_read(32'h4, rd, rs, rde, st, vc, vp);
        n_cmp++; if ({rd, rs, rde} !== {32'h12, 2'b10}) begin n_err++; $display("FAIL parity_read: got %h s=%b d=%b want 12/1/0", rd, rs, rde); end
        n_cmp++; if (st !== 2 || s_err_cnt !== 8'd2) begin n_err++; $display("FAIL parity_scrub: got stall=%0d cnt=%0d want 2/2", st, s_err_cnt); end
        do_read(32'h4, rd, rs, rde, st, vc, vp);
        n_cmp++; if ({rs, rde} !== 2'b00) begin n_err++; $display("FAIL parity_scrubbed: got %b want 00", {rs, rde}); end
        do_inject(32'h4, 6'd45);
        do_read(32'h4, rd, rs, rde, st, vc, vp);
        n_cmp++; if ({rd, rs, rde} !== {32'h12, 2'b00}) begin n_err++; $display("FAIL inj_oob: got %h s=%b d=%b want 12/0/0", rd, rs, rde); end
    endtask

    task automatic test_collision();
        ALUResultM = 32'h8; WriteDataM = 32'h55; MemWriteM = 1'b1; MemReadM = 1'b1;
        @(posedge clk); @(negedge clk);
        MemWriteM = 1'b0; MemReadM = 1'b0;
        n_cmp++; if ({stall_mem, rd_valid} !== 2'b00) begin n_err++; $display("FAIL collide_nostall: got %b want 00", {stall_mem, rd_valid}); end
        @(negedge clk);
        n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL collide_novalid: got %b want 0", rd_valid); end
        do_read(32'h8, rd, rs, rde, st, vc, vp);
        n_cmp++; if (rd !== 32'h55) begin n_err++; $display("FAIL collide_data: got %h want 00000055", rd); end
        do_write(32'h104, 32'hABCD);
        do_read(32'h4, rd, rs, rde, st, vc, vp);
        n_cmp++; if (rd !== 32'hABCD) begin n_err++; $display("FAIL alias_data: got %h want 0000abcd", rd); end
        do_read(32'h7, rd, rs, rde, st, vc, vp);
        n_cmp++; if (rd !== 32'hABCD) begin n_err++; $display("FAIL byteoff_data: got %h want 0000abcd", rd); end
    endtask

    task automatic test_stall_ignore();
        do_inject(32'h4, 6'd5);
        ALUResultM = 32'h4; MemReadM = 1'b1;
        @(posedge clk); @(negedge clk);
        MemReadM = 1'b0;
        // Store presented during RD and SCRUB must be dropped.
        WriteDataM = 32'hDEAD; MemWriteM = 1'b1;
        n_cmp++; if (stall_mem !== 1'b1) begin n_err++; $display("FAIL ign_stall_rd: got %b want 1", stall_mem); end
        @(negedge clk);
        n_cmp++; if ({stall_mem, rd_valid, s_err, ReadDataM} !== {3'b111, 32'hABCD}) begin n_err++; $display("FAIL ign_scrub: got stall=%b v=%b s=%b %h want 1/1/1/abcd", stall_mem, rd_valid, s_err, ReadDataM); end
        @(negedge clk);
        MemWriteM = 1'b0;
        n_cmp++; if ({stall_mem, rd_valid} !== 2'b00) begin n_err++; $display("FAIL ign_idle: got %b want 00", {stall_mem, rd_valid}); end
        do_read(32'h4, rd, rs, rde, st, vc, vp);
        n_cmp++; if ({rd, rs, rde} !== {32'hABCD, 2'b00}) begin n_err++; $display("FAIL ign_data: got %h s=%b d=%b want abcd/0/0", rd, rs, rde); end
        n_cmp++; if (s_err_cnt !== 8'd3) begin n_err++; $display("FAIL ign_cnt: got %0d want 3", s_err_cnt); end
    endtask

    task automatic test_reset_mid_scrub();
        do_inject(32'h4, 6'd7);
        ALUResultM = 32'h4; MemReadM = 1'b1;
        @(posedge clk); @(negedge clk);
        MemReadM = 1'b0;
        @(negedge clk);
        n_cmp++; if (stall_mem !== 1'b1) begin n_err++; $display("FAIL mid_in_scrub: got %b want 1", stall_mem); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if ({stall_mem, rd_valid, s_err, d_err} !== 4'b0) begin n_err++; $display("FAIL mid_flags: got %b want 0000", {stall_mem, rd_valid, s_err, d_err}); end
        n_cmp++; if ({ReadDataM, s_err_cnt, d_err_cnt} !== 48'h0) begin n_err++; $display("FAIL mid_regs: got %h %0d %0d want 0", ReadDataM, s_err_cnt, d_err_cnt); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_read(32'h4, rd, rs, rde, st, vc, vp);
        n_cmp++; if ({rd, rs, rde, st} !== {32'h0, 2'b00, 32'd1}) begin n_err++; $display("FAIL mid_after: got %h s=%b d=%b stall=%0d want 0/0/0/1", rd, rs, rde, st); end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_single();
        test_double();
        test_parity();
        test_collision();
        test_stall_ignore();
        test_reset_mid_scrub();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
